// File: rtl/shift_pkg.sv
// Shared encodings and defaults for the multi-cycle shift sequencer.
package shift_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int AMT_W_DEF = 3;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_one_step.sv
// Combinational single-bit shift/rotate stage; also usable by a single-cycle shifter.
module shift_one_step
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] next_value,
    output logic             carry
);

    // One step of the selected operation and the bit that leaves the word
    always_comb begin
        next_value = value;
        carry      = 1'b0;
        case (op)
            OP_LSL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                carry      = value[WIDTH-1];
            end
            OP_LSR: begin
                next_value = {1'b0, value[WIDTH-1:1]};
                carry      = value[0];
            end
            OP_ASR: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                carry      = value[0];
            end
            OP_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                carry      = value[0];
            end
            default: begin
                next_value = value;
                carry      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit per clock under a start/busy/done handshake.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic [WIDTH-1:0] in_bit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_bit,
    output logic             carry_out,
    output logic             zero
);

    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
    localparam logic [AMT_W-1:0] CNT_ZERO = AMT_W'(0);

    shift_state_t     state_r;
    shift_state_t     next_state_s;
    logic [AMT_W-1:0] count_r;
    logic [1:0]       op_r;
    logic             load_s;
    logic             step_s;
    logic [WIDTH-1:0] step_value_s;
    logic             step_carry_s;

    shift_one_step #(.WIDTH(WIDTH)) u_step (
        .value      (out_bit),
        .op         (op_r),
        .next_value (step_value_s),
        .carry      (step_carry_s)
    );

    // Next-state decode; a start in DONE reloads directly without visiting IDLE
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    load_s       = 1'b1;
                    next_state_s = (shift_amt != CNT_ZERO) ? SHIFT : DONE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                step_s = 1'b1;
                if (count_r == CNT_ONE) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State and handshake registers; busy/done are registered copies of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy    <= (next_state_s == SHIFT);
            done    <= (next_state_s == DONE);
        end
    end

    // Operand load and per-step datapath update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bit   <= '0;
            carry_out <= 1'b0;
            count_r   <= CNT_ZERO;
            op_r      <= OP_LSL;
        end else if (load_s) begin
            out_bit   <= in_bit;
            carry_out <= 1'b0;
            count_r   <= shift_amt;
            op_r      <= op;
        end else if (step_s) begin
            out_bit   <= step_value_s;
            carry_out <= step_carry_s;
            count_r   <= count_r - CNT_ONE;
        end else begin
            out_bit   <= out_bit;
            carry_out <= carry_out;
            count_r   <= count_r;
        end
    end

    assign zero = (out_bit == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed, table-driven bench for shift_sequencer with hand-computed results.
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [2:0] shift_amt;
    logic [7:0] in_bit;
    logic       busy;
    logic       done;
    logic [7:0] out_bit;
    logic       carry_out;
    logic       zero;

    int n_cmp;
    int n_bad;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [7:0] in_v;
        logic [2:0] amt;
        logic [7:0] exp_out;
        logic       exp_c;
        logic       exp_z;
    } vec_t;

    vec_t vecs[8];

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .shift_amt (shift_amt),
        .in_bit    (in_bit),
        .busy      (busy),
        .done      (done),
        .out_bit   (out_bit),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Starts an operation from the current (non-busy) cycle and checks latency and result
    task automatic run_and_check(input string name, input logic [1:0] o, input logic [7:0] v,
                                 input logic [2:0] a, input logic [7:0] eo, input logic ec,
                                 input logic ez);
        int edges;
        int busy_cycles;
        op        = o;
        in_bit    = v;
        shift_amt = a;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 16) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        chk({name, " done_edge"}, edges, 32'(a));
        chk({name, " busy_cycles"}, busy_cycles, 32'(a));
        chk({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({name, " out_bit"}, {24'd0, out_bit}, {24'd0, eo});
        chk({name, " carry_out"}, {31'd0, carry_out}, {31'd0, ec});
        chk({name, " zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    initial begin
        int   edges;
        logic saw_done;
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        shift_amt = 3'd0;
        in_bit    = 8'h00;

        vecs[0] = '{"lsl1",  2'b00, 8'b10001000, 3'd1, 8'b00010000, 1'b1, 1'b0};
        vecs[1] = '{"lsr3",  2'b01, 8'b11100000, 3'd3, 8'b00011100, 1'b0, 1'b0};
        vecs[2] = '{"asr2",  2'b10, 8'b11010111, 3'd2, 8'b11110101, 1'b1, 1'b0};
        vecs[3] = '{"ror4",  2'b11, 8'b01011110, 3'd4, 8'b11100101, 1'b1, 1'b0};
        vecs[4] = '{"lsl7",  2'b00, 8'h81,       3'd7, 8'h80,       1'b0, 1'b0};
        vecs[5] = '{"ror7",  2'b11, 8'h01,       3'd7, 8'h02,       1'b0, 1'b0};
        vecs[6] = '{"lsr1z", 2'b01, 8'h01,       3'd1, 8'h00,       1'b1, 1'b1};
        vecs[7] = '{"asr7",  2'b10, 8'h80,       3'd7, 8'hFF,       1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst out_bit", {24'd0, out_bit}, 32'd0);
        chk("rst carry", {31'd0, carry_out}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_and_check(vecs[i].name, vecs[i].op, vecs[i].in_v, vecs[i].amt,
                          vecs[i].exp_out, vecs[i].exp_c, vecs[i].exp_z);
            @(posedge clk);
            #1;
        end

        // amt=0, then a back-to-back start issued in the DONE cycle
        run_and_check("amt0", 2'b00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1);
        op        = 2'b01;
        in_bit    = 8'b10110110;
        shift_amt = 3'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b accepted busy", {31'd0, busy}, 32'd1);
        chk("b2b loaded out", {24'd0, out_bit}, 32'h000000B6);
        // new operands with start high mid-shift must be ignored
        op        = 2'b00;
        in_bit    = 8'hFF;
        shift_amt = 3'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignore busy", {31'd0, busy}, 32'd1);
        chk("ignore mid out", {24'd0, out_bit}, 32'h0000005B);
        edges = 1;
        while (!done && edges < 16) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("b2b done_edge", edges, 32'd2);
        chk("b2b out", {24'd0, out_bit}, 32'h0000002D);
        chk("b2b carry", {31'd0, carry_out}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold out", {24'd0, out_bit}, 32'h0000002D);
        chk("hold carry", {31'd0, carry_out}, 32'd1);
        chk("hold done", {31'd0, done}, 32'd0);

        // reset pulse in the middle of a long shift
        op        = 2'b00;
        in_bit    = 8'hFF;
        shift_amt = 3'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-rst out", {24'd0, out_bit}, 32'h000000F8);
        rst_n = 1'b0;
        #1;
        chk("midrst out", {24'd0, out_bit}, 32'd0);
        chk("midrst carry", {31'd0, carry_out}, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("postrst no done", {31'd0, saw_done}, 32'd0);
        run_and_check("fresh", 2'b11, 8'b01011110, 3'd4, 8'b11100101, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
